// File: rtl/wb_led_pattern_master.sv
// wb_led_pattern_master
// Wishbone initiator that steps a 4-bit LED pattern on every divided tick.
// Each step writes the pattern to responder address 0, leaves the bus idle
// for one cycle, reads the value back and compares it with what was written.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   enable               runs the tick divider and allows steps
//   mode[1:0]            0 count, 1 walking-one, 2 ping-pong, 3 all-toggle
//   clear_err            pulse clearing the error and timeout flags
//   wbm_*                Wishbone initiator port (address always 0)
//   busy                 step in progress (FSM not idle)
//   pattern[3:0]         last pattern written
//   error, timeout       sticky readback-mismatch and ack-timeout flags
//   dbg_state[2:0]       current FSM state, for observation only
// Bus handshake: a transfer is presented while wbm_cycle=1 and completes on the
// first rising edge where wbm_ack=1; ack may be combinational from wbm_cycle,
// and ack seen while wbm_cycle=0 is ignored.
module wb_led_pattern_master #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 16,
    parameter int TICK_DIV   = 1000000,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  clear_err,
    output logic [ADDR_WIDTH-1:0] wbm_address,
    output logic [DATA_WIDTH-1:0] wbm_writedata,
    input  logic [DATA_WIDTH-1:0] wbm_readdata,
    output logic                  wbm_write,
    output logic                  wbm_cycle,
    input  logic                  wbm_ack,
    output logic                  busy,
    output logic [3:0]            pattern,
    output logic                  error,
    output logic                  timeout,
    output logic [2:0]            dbg_state
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_GAP  = 3'd2,   // one bus-idle cycle between the write and the read
        S_RD   = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [1:0]            last_mode_q, last_mode_d;
    logic                  mode_vld_q, mode_vld_d;
    logic                  dir_q, dir_d;          // 1 = shifting up (toward bit 3)
    logic [3:0]            pattern_q, pattern_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            rdata_q, rdata_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  error_q, error_d;
    logic                  timeout_q, timeout_d;

    logic       tick;
    logic       start;
    logic [3:0] nxt_pat;
    logic       nxt_dir;
    logic       unused_rd;

    assign unused_rd = &{1'b0, wbm_readdata[DATA_WIDTH-1:4]};

    assign tick  = enable && (cnt_q == CNT_W'(TICK_DIV - 1));
    assign start = enable && (tick || pending_q);

    always_comb begin
        if (!enable || tick) cnt_d = '0;
        else                 cnt_d = cnt_q + 1'b1;
    end

    // Next pattern. The first step after reset always loads the seed, so
    // that mode 0 starts its count at 0000 rather than 0001.
    always_comb begin
        nxt_pat = pattern_q;
        nxt_dir = dir_q;
        if (!mode_vld_q || (mode != last_mode_q)) begin
            case (mode)
                2'd0:    nxt_pat = 4'b0000;
                2'd1:    nxt_pat = 4'b0001;
                2'd2: begin
                    nxt_pat = 4'b0001;
                    nxt_dir = 1'b1;
                end
                default: nxt_pat = 4'b1111;
            endcase
        end else begin
            case (mode)
                2'd0:    nxt_pat = pattern_q + 4'd1;
                2'd1:    nxt_pat = {pattern_q[2:0], pattern_q[3]};
                2'd2: begin
                    if (pattern_q == 4'b1000) begin
                        nxt_pat = pattern_q >> 1;
                        nxt_dir = 1'b0;
                    end else if (pattern_q == 4'b0001) begin
                        nxt_pat = pattern_q << 1;
                        nxt_dir = 1'b1;
                    end else if (dir_q) begin
                        nxt_pat = pattern_q << 1;
                    end else begin
                        nxt_pat = pattern_q >> 1;
                    end
                end
                default: nxt_pat = ~pattern_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        last_mode_d = last_mode_q;
        mode_vld_d  = mode_vld_q;
        dir_d       = dir_q;
        pattern_d   = pattern_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        wait_d      = '0;
        error_d     = error_q;
        timeout_d   = timeout_q;

        // One-deep step queue: a tick arriving while busy is remembered once.
        if (!enable)                        pending_d = 1'b0;
        else if (state_q != S_IDLE && tick) pending_d = 1'b1;
        else                                pending_d = pending_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WR;
                    pattern_d   = nxt_pat;
                    dir_d       = nxt_dir;
                    last_mode_d = mode;
                    mode_vld_d  = 1'b1;
                    wdata_d     = {{(DATA_WIDTH-4){1'b0}}, nxt_pat};
                    pending_d   = 1'b0;
                end
            end
            S_WR, S_RD: begin
                if (wbm_ack) begin
                    if (state_q == S_WR) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_CHK;
                        rdata_d = wbm_readdata[3:0];
                    end
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    // Last allowed cycle without ack: abandon the step.
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_GAP: state_d = S_RD;
            S_CHK: begin
                if (rdata_q != pattern_q) error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Clearing wins over a flag being set in the same cycle.
        if (clear_err) begin
            error_d   = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            last_mode_q <= 2'd0;
            mode_vld_q  <= 1'b0;
            dir_q       <= 1'b1;
            pattern_q   <= 4'd0;
            wdata_q     <= '0;
            rdata_q     <= 4'd0;
            wait_q      <= '0;
            error_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            last_mode_q <= last_mode_d;
            mode_vld_q  <= mode_vld_d;
            dir_q       <= dir_d;
            pattern_q   <= pattern_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            wait_q      <= wait_d;
            error_q     <= error_d;
            timeout_q   <= timeout_d;
        end
    end

    assign wbm_address   = '0;
    assign wbm_writedata = wdata_q;
    assign wbm_cycle     = (state_q == S_WR) || (state_q == S_RD);
    assign wbm_write     = (state_q == S_WR);
    assign busy          = (state_q != S_IDLE);
    assign pattern       = pattern_q;
    assign error         = error_q;
    assign timeout       = timeout_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_wb_led_pattern_master.sv
module tb_wb_led_pattern_master;

    localparam int TICK_DIV = 4;
    localparam int TIMEOUT  = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic        clear_err;
    logic [0:0]  wbm_address;
    logic [15:0] wbm_writedata;
    logic [15:0] wbm_readdata;
    logic        wbm_write;
    logic        wbm_cycle;
    logic        wbm_ack;
    logic        busy;
    logic [3:0]  pattern;
    logic        error;
    logic        timeout;
    logic [2:0]  dbg_state;

    wb_led_pattern_master #(
        .ADDR_WIDTH(1), .DATA_WIDTH(16), .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .clear_err(clear_err),
        .wbm_address(wbm_address), .wbm_writedata(wbm_writedata),
        .wbm_readdata(wbm_readdata), .wbm_write(wbm_write), .wbm_cycle(wbm_cycle),
        .wbm_ack(wbm_ack), .busy(busy), .pattern(pattern), .error(error),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    // ---------------- responder model ----------------
    logic        ack_en;
    int          ack_delay;
    int          dcnt;       // cycles wbm_cycle has been high, including this one
    logic        rd_zero;
    logic [15:0] mem;

    assign wbm_ack      = wbm_cycle && ack_en && (dcnt > ack_delay);
    assign wbm_readdata = rd_zero ? 16'h0000 : mem;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int checks;
    int errors;
    int writes_seen;
    int read_cyc;
    int run_len, last_run;
    int idle_len, last_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] p);
        exp_q.push_back({12'h000, p});
    endtask

    // One clock: advance to the falling edge, update the responder, then
    // observe the bus and the status outputs.
    task automatic cyc();
        logic [15:0] e;
        @(negedge clk);
        if (wbm_cycle) dcnt = dcnt + 1;
        else           dcnt = 0;
        #1;
        if (wbm_cycle && wbm_write && wbm_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", wbm_writedata, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_data", wbm_writedata, e);
            end
            chk("write_addr", wbm_address, 0);
            mem = wbm_writedata;
            writes_seen++;
        end
        if (wbm_cycle && !wbm_write) read_cyc++;
        if (wbm_cycle) run_len++;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (!busy) idle_len++;
        else if (idle_len != 0) begin
            last_idle = idle_len;
            idle_len  = 0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            cyc();
            t++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic run_steps(input int n, input int budget);
        int target = writes_seen + n;
        int t = 0;
        enable = 1'b1;
        while (writes_seen < target && t < budget) begin
            cyc();
            t++;
        end
        enable = 1'b0;
        chk("step_count", writes_seen, target);
        wait_idle(100);
    endtask

    task automatic wait_cycle_high(input int budget);
        int t = 0;
        while (!wbm_cycle && t < budget) begin
            cyc();
            t++;
        end
        chk("cycle_started", wbm_cycle, 1);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
    endtask

    initial begin
        int rc;
        int ws;
        checks = 0; errors = 0; writes_seen = 0; read_cyc = 0;
        run_len = 0; last_run = 0; idle_len = 0; last_idle = 0;
        reset = 1'b1; enable = 1'b0; mode = 2'd0; clear_err = 1'b0;
        ack_en = 1'b1; ack_delay = 0; dcnt = 0; rd_zero = 1'b0; mem = 16'h0;

        // reset state
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_cycle", wbm_cycle, 0);
        chk("rst_write", wbm_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pattern", pattern, 0);
        chk("rst_error", error, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_wdata", wbm_writedata, 0);
        chk("rst_addr", wbm_address, 0);
        chk("rst_state", dbg_state, 0);

        // mode 0 count from seed
        push(4'h0); push(4'h1); push(4'h2);
        run_steps(3, 200);
        chk("m0_pattern", pattern, 4'h2);
        chk("m0_error", error, 0);

        // walking one
        mode = 2'd1;
        push(4'h1); push(4'h2); push(4'h4); push(4'h8); push(4'h1);
        run_steps(5, 300);
        chk("m1_pattern", pattern, 4'h1);

        // ping-pong
        mode = 2'd2;
        push(4'h1); push(4'h2); push(4'h4); push(4'h8);
        push(4'h4); push(4'h2); push(4'h1); push(4'h2);
        run_steps(8, 400);
        chk("m2_pattern", pattern, 4'h2);

        // all-toggle
        mode = 2'd3;
        push(4'hF); push(4'h0); push(4'hF);
        run_steps(3, 200);
        chk("m3_pattern", pattern, 4'hF);

        // back to count: reseeds
        mode = 2'd0;
        push(4'h0); push(4'h1);
        run_steps(2, 200);
        chk("m0b_error", error, 0);

        // readback mismatch, then clear
        rd_zero = 1'b1;
        push(4'h2);
        run_steps(1, 100);
        rd_zero = 1'b0;
        chk("mismatch_error", error, 1);
        pulse_clear();
        chk("error_cleared", error, 0);

        // ack timeout: no read may follow the abandoned write
        ack_en = 1'b0;
        rc = read_cyc;
        ws = writes_seen;
        enable = 1'b1;
        wait_cycle_high(20);
        enable = 1'b0;
        wait_idle(40);
        chk("to_cycle_len", last_run, TIMEOUT);
        chk("to_flag", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_no_read", read_cyc, rc);
        chk("to_no_write", writes_seen, ws);
        chk("to_pattern", pattern, 4'h3);
        ack_en = 1'b1;
        pulse_clear();
        chk("timeout_cleared", timeout, 0);

        // slow responder: the pending step launches after a single idle cycle
        ack_delay = 6;
        push(4'h4); push(4'h5);
        ws = writes_seen;
        enable = 1'b1;
        begin
            int t = 0;
            while (writes_seen < ws + 1 && t < 100) begin cyc(); t++; end
        end
        last_idle = 0;
        run_steps(1, 100);
        chk("pending_gap", last_idle, 1);
        chk("pending_pattern", pattern, 4'h5);
        ack_delay = 0;

        // reset in the middle of a bus cycle
        rd_zero = 1'b1;
        push(4'h6);
        run_steps(1, 100);
        rd_zero = 1'b0;
        chk("pre_rst_error", error, 1);
        ack_en = 1'b0;
        enable = 1'b1;
        wait_cycle_high(20);
        reset = 1'b1;
        cyc();
        chk("mid_rst_cycle", wbm_cycle, 0);
        chk("mid_rst_pattern", pattern, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_wdata", wbm_writedata, 0);
        reset = 1'b0;
        enable = 1'b0;
        ack_en = 1'b1;
        cyc();

        // first step after reset seeds again
        push(4'h0);
        run_steps(1, 100);
        chk("post_rst_pattern", pattern, 4'h0);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
